div_unit: RTL and testbench

//  Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions.

---
 rtl/div_unit_pkg.sv | 31 +++
 rtl/div_step.sv | 21 ++
 rtl/div_unit.sv | 121 ++++++++++++
 tb/tb_div_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared types and helpers for the iterative RV32M divider
package div_unit_pkg;

  localparam int DATA_W    = 32;
  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    DivOp_DIV,
    DivOp_DIVU,
    DivOp_REM,
    DivOp_REMU
  } DivOp;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } div_state_e;

  function automatic logic is_signed_op(input DivOp op);
    return (op == DivOp_DIV) || (op == DivOp_REM);
  endfunction

  function automatic logic [DATA_W-1:0] select_result(input DivOp op,
                                                      input logic [DATA_W-1:0] quo,
                                                      input logic [DATA_W-1:0] rem);
    return ((op == DivOp_REM) || (op == DivOp_REMU)) ? rem : quo;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
  import div_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);

  logic [DATA_W:0] shifted;
  logic            fits;

  assign shifted  = {rem, quo[DATA_W-1]};
  assign fits     = shifted >= {1'b0, divisor};
  // The true difference is below the divisor, so its low 32 bits are exact.
  assign rem_next = shifted[DATA_W-1:0] - (fits ? divisor : '0);
  assign quo_next = {quo[DATA_W-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M DIV/DIVU/REM/REMU unit; DIV_UNIT_EARLY_OUT_EN enables 1-cycle early-out
module div_unit
  import div_unit_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_kill,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_dataA,
  input  logic [DATA_W-1:0] i_dataB,
  output logic              o_busy,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result
);

  div_state_e        state_q, state_d;
  DivOp              op_q;
  logic              neg_quo_q, neg_rem_q, zero_q, ovf_q;
  logic [DATA_W-1:0] rem_q, quo_q, divisor_q, result_q;
  logic [4:0]        cnt_q;

  DivOp              op_in;
  logic              signed_in, sign_a, sign_b, zero_in, ovf_in, early_in;
  logic [DATA_W-1:0] abs_a, abs_b, early_quo, early_rem;
  logic [DATA_W-1:0] step_rem, step_quo, fix_quo, fix_rem;

  assign op_in     = DivOp'(i_op);
  assign signed_in = is_signed_op(op_in);
  assign sign_a    = signed_in & i_dataA[DATA_W-1];
  assign sign_b    = signed_in & i_dataB[DATA_W-1];
  assign abs_a     = sign_a ? ('0 - i_dataA) : i_dataA;
  assign abs_b     = sign_b ? ('0 - i_dataB) : i_dataB;
  assign zero_in   = (i_dataB == '0);
  assign ovf_in    = signed_in && (i_dataA == 32'h8000_0000) && (i_dataB == 32'hFFFF_FFFF);

`ifdef DIV_UNIT_EARLY_OUT_EN
  assign early_in  = zero_in | ovf_in | (abs_a < abs_b);
`else
  assign early_in  = 1'b0;
`endif

  assign early_quo = zero_in ? 32'hFFFF_FFFF : (ovf_in ? 32'h8000_0000 : '0);
  assign early_rem = ovf_in ? '0 : i_dataA;

  div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Special cases override the sign fix-up; a zero divisor leaves rem = A naturally.
  always_comb begin
    fix_quo = neg_quo_q ? ('0 - quo_q) : quo_q;
    fix_rem = neg_rem_q ? ('0 - rem_q) : rem_q;
    if (zero_q) begin
      fix_quo = 32'hFFFF_FFFF;
    end else if (ovf_q) begin
      fix_quo = 32'h8000_0000;
      fix_rem = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = early_in ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (i_kill) state_d = ST_IDLE;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      op_q      <= DivOp_DIV;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (i_start && !i_kill) begin
          op_q      <= op_in;
          neg_quo_q <= sign_a ^ sign_b;
          neg_rem_q <= sign_a;
          zero_q    <= zero_in;
          ovf_q     <= ovf_in;
          rem_q     <= '0;
          quo_q     <= abs_a;
          divisor_q <= abs_b;
          cnt_q     <= 5'(DIV_STEPS - 1);
          if (early_in) result_q <= select_result(op_in, early_quo, early_rem);
        end
        ST_CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          if (cnt_q != '0) cnt_q <= cnt_q - 5'd1;
        end
        ST_FIX: if (!i_kill) result_q <= select_result(op_q, fix_quo, fix_rem);
        default: ;
      endcase
    end
  end

  assign o_busy   = (state_q != ST_IDLE);
  assign o_valid  = (state_q == ST_DONE) && !i_kill;
  assign o_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit against an arithmetic reference model
module tb_div_unit;
  import div_unit_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_kill  = 1'b0;
  logic [1:0]  i_op    = 2'd0;
  logic [31:0] i_dataA = 32'd0;
  logic [31:0] i_dataB = 32'd0;
  logic        o_busy, o_valid;
  logic [31:0] o_result;

  int passed = 0;
  int total  = 0;
  logic [31:0] last_result = 32'd0;

  div_unit dut (
    .i_clock (i_clock), .i_reset (i_reset), .i_start (i_start), .i_kill (i_kill),
    .i_op (i_op), .i_dataA (i_dataA), .i_dataB (i_dataB),
    .o_busy (o_busy), .o_valid (o_valid), .o_result (o_result)
  );

  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic sgn;
    logic [31:0] q, r;
    sgn = (op == 2'(DivOp_DIV)) || (op == 2'(DivOp_REM));
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return (op[1]) ? r : q;
  endfunction

  function automatic int model_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
`ifdef DIV_UNIT_EARLY_OUT_EN
    logic sgn;
    logic [31:0] ma, mb;
    sgn = (op == 2'(DivOp_DIV)) || (op == 2'(DivOp_REM));
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || ma < mb) return 0;
`else
    if (op == 2'b11 && a == b && a == 32'h1234_5678) return 0;
`endif
    return 33;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    logic [31:0] exp;
    exp = model(op, a, b);
    i_op = op; i_dataA = a; i_dataB = b; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while (!o_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(model_latency(op, a, b)));
    check({tag, "_result"}, o_result, exp);
    tick();
    check({tag, "_valid_pulse"}, {31'd0, o_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
    last_result = exp;
  endtask

  initial begin
    int valids;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    tick(); tick();
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_result", o_result, 32'd0);
    i_reset = 1'b1;
    tick();

    run_op("divu_100_7", 2'(DivOp_DIVU), 32'd100, 32'd7);
    run_op("remu_100_7", 2'(DivOp_REMU), 32'd100, 32'd7);
    run_op("div_m7_2", 2'(DivOp_DIV), -32'sd7, 32'd2);
    run_op("rem_m7_2", 2'(DivOp_REM), -32'sd7, 32'd2);
    run_op("div_x_0", 2'(DivOp_DIV), 32'hDEAD_BEEF, 32'd0);
    run_op("divu_x_0", 2'(DivOp_DIVU), 32'h0000_1234, 32'd0);
    run_op("rem_5_0", 2'(DivOp_REM), 32'd5, 32'd0);
    run_op("rem_m5_0", 2'(DivOp_REM), -32'sd5, 32'd0);
    run_op("div_ovf", 2'(DivOp_DIV), 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 2'(DivOp_REM), 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_3_9", 2'(DivOp_DIVU), 32'd3, 32'd9);
    run_op("divu_max_1", 2'(DivOp_DIVU), 32'hFFFF_FFFF, 32'd1);
    run_op("div_min_2", 2'(DivOp_DIV), 32'h8000_0000, 32'd2);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(1, 255));
        1: rb = -32'($urandom_range(1, 255));
        2: rb = (i % 6 == 0) ? 32'd0 : $urandom;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op("random", rop, ra, rb);
    end

    // Second start while busy must be ignored.
    i_op = 2'(DivOp_DIVU); i_dataA = 32'd50; i_dataB = 32'd5; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (4) tick();
    i_dataA = 32'd99; i_dataB = 32'd3; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    valids = 0;
    for (int c = 0; c < 45; c++) begin
      if (o_valid) begin
        valids++;
        check("double_start_result", o_result, 32'd10);
      end
      tick();
    end
    check("double_start_valids", 32'(valids), 32'd1);
    last_result = 32'd10;

    // Kill during CALC.
    i_op = 2'(DivOp_DIVU); i_dataA = 32'd1000; i_dataB = 32'd3; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (9) tick();
    i_kill = 1'b1;
    check("kill_valid_same_cycle", {31'd0, o_valid}, 32'd0);
    tick();
    i_kill = 1'b0;
    check("kill_busy", {31'd0, o_busy}, 32'd0);
    check("kill_result", o_result, last_result);
    valids = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_valid) valids++;
      tick();
    end
    check("kill_no_valid", 32'(valids), 32'd0);
    check("kill_result_hold", o_result, last_result);

    // Reset during CALC.
    i_op = 2'(DivOp_DIV); i_dataA = 32'd777; i_dataB = 32'd7; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (19) tick();
    i_reset = 1'b0;
    tick();
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_result", o_result, 32'd0);
    i_reset = 1'b1;
    valids = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_valid) valids++;
      tick();
    end
    check("rst_no_valid", 32'(valids), 32'd0);

    run_op("after_reset", 2'(DivOp_REMU), 32'd100, 32'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
